// File: rtl/wallace_mac_accumulator.sv
// Streaming signed dot-product stage: operand register -> 4x4 Wallace tree multiplier
// (signed A x unsigned B) -> product register -> saturating-count accumulator with sticky overflow.
module wallace_mac_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

  state_t state, state_next;

  logic             in_fire, out_fire;
  logic             need_first;
  logic             s1_valid, s1_last, s1_first;
  logic [3:0]       s1_a, s1_b;
  logic             s2_valid, s2_last, s2_first;
  logic [7:0]       s2_prod;
  logic [7:0]       prod;
  logic [ACC_W-1:0] acc, prod_ext, acc_sum;
  logic [CNT_W-1:0] count;
  logic             ovf, add_ovf;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next-state uses in_valid directly so in_ready never feeds back into this block.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      RUN: begin
        in_ready = !rst;
        if (in_valid && in_last) state_next = FLUSH;
      end
      FLUSH: begin
        if (s2_valid && s2_last) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Wallace tree on the stage-1 registers: rows of sign-extended A, two carry-save layers,
  // then a ripple adder. Everything is kept mod 256, which is exact since |A*B| <= 120.
  logic [7:0]      a_ext;
  logic [3:0][7:0] pp;
  logic [7:0]      l1_s, l1_c, l2_s, l2_c, rc;

  assign a_ext = {{4{s1_a[3]}}, s1_a};

  for (genvar j = 0; j < 4; j++) begin : g_pp
    assign pp[j] = s1_b[j] ? (a_ext << j) : 8'd0;
  end

  assign l1_c[0] = 1'b0;
  assign l2_c[0] = 1'b0;
  assign rc[0]   = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_tree
    assign l1_s[i] = pp[0][i] ^ pp[1][i] ^ pp[2][i];
    assign l2_s[i] = l1_s[i] ^ l1_c[i] ^ pp[3][i];
    assign prod[i] = l2_s[i] ^ l2_c[i] ^ rc[i];
    if (i < 7) begin : g_carry
      assign l1_c[i+1] = maj(pp[0][i], pp[1][i], pp[2][i]);
      assign l2_c[i+1] = maj(l1_s[i], l1_c[i], pp[3][i]);
      assign rc[i+1]   = maj(l2_s[i], l2_c[i], rc[i]);
    end
  end

  always_comb begin
    prod_ext = ACC_W'($signed(s2_prod));
    acc_sum  = acc + prod_ext;
    add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
  end

  // Pipeline and accumulator; reset drops every in-flight beat and the partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      need_first <= 1'b1;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_first   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      s2_first   <= 1'b0;
      s2_prod    <= '0;
      acc        <= '0;
      count      <= '0;
      ovf        <= 1'b0;
    end else begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_a       <= in_a;
        s1_b       <= in_b;
        s1_last    <= in_last;
        s1_first   <= need_first;
        need_first <= 1'b0;
      end
      if (out_fire) need_first <= 1'b1;

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod  <= prod;
        s2_last  <= s1_last;
        s2_first <= s1_first;
      end

      if (s2_valid) begin
        if (s2_first) begin
          acc   <= prod_ext;
          count <= CNT_W'(1);
          ovf   <= 1'b0;
        end else begin
          acc <= acc_sum;
          if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
          ovf <= ovf | add_ovf;
        end
      end
    end
  end

  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule
